// File: rtl/diff_freq_tick_gen_if.sv
// rtl/diff_freq_tick_gen_if.sv - control, divisor and tick signals of the per-bit tick generator
interface diff_freq_tick_gen_if #(
  parameter int DATA_BIT  = 16,
  parameter int DIV_WIDTH = 16
);
  logic                 i_start;
  logic                 i_stop;
  logic                 i_repeat;
  logic [DATA_BIT-1:0]  i_freq_sel;
  logic [DIV_WIDTH-1:0] i_high_div;
  logic [DIV_WIDTH-1:0] i_low_div;
  logic                 i_bit_tick;
  logic                 o_tick;
  logic                 o_busy;
  logic                 o_done_tick;
  logic                 o_sync_err;

  modport slave (
    input  i_start, i_stop, i_repeat, i_freq_sel, i_high_div, i_low_div, i_bit_tick,
    output o_tick, o_busy, o_done_tick, o_sync_err
  );

  modport master (
    output i_start, i_stop, i_repeat, i_freq_sel, i_high_div, i_low_div, i_bit_tick,
    input  o_tick, o_busy, o_done_tick, o_sync_err
  );
endinterface

// File: rtl/diff_freq_tick_gen.sv
// rtl/diff_freq_tick_gen.sv - per-bit high/low rate baud tick generator with bit-alignment check
module diff_freq_tick_gen #(
  parameter int DATA_BIT     = 16,
  parameter int TICK_PER_BIT = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  diff_freq_tick_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, WRAP} state_t;

  state_t               state, state_d;
  logic [DATA_BIT-1:0]  sel_sh;
  logic [DIV_WIDTH-1:0] hdiv_sh, ldiv_sh;
  logic [DIV_WIDTH-1:0] presc;
  logic [7:0]           tcnt;
  logic [5:0]           bidx;
  logic                 exp_bt;
  logic                 err;

  logic                 sel_bit;
  logic [DIV_WIDTH-1:0] cur_div;
  logic                 tick;
  logic                 last_tick;
  logic                 last_bit;
  logic                 load;
  logic                 advance;

  // Mask-and-reduce keeps every bit of bidx in use without an oversized index.
  assign sel_bit   = |(sel_sh & (DATA_BIT'(1) << bidx));
  assign cur_div   = sel_bit ? hdiv_sh : ldiv_sh;
  assign tick      = (state == RUN) && (presc == cur_div);
  assign last_tick = (tcnt == 8'(TICK_PER_BIT - 1));
  assign last_bit  = (bidx == 6'(DATA_BIT - 1));
  assign advance   = (state == RUN) && !bus.i_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (bus.i_stop)                        state_d = IDLE;
        else if (tick && last_tick && last_bit) state_d = WRAP;
      end
      WRAP: begin
        // Stop is not looked at here, matching the serial stage's DONE state.
        if (bus.i_repeat) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sh  <= '0;
      hdiv_sh <= '0;
      ldiv_sh <= '0;
      presc   <= '0;
      tcnt    <= '0;
      bidx    <= '0;
      exp_bt  <= 1'b0;
      err     <= 1'b0;
    end else begin
      exp_bt <= 1'b0;
      if (bus.i_bit_tick != exp_bt) err <= 1'b1;
      if (load) begin
        sel_sh  <= bus.i_freq_sel;
        hdiv_sh <= bus.i_high_div;
        ldiv_sh <= bus.i_low_div;
        presc   <= '0;
        tcnt    <= '0;
        bidx    <= '0;
      end else if (advance) begin
        if (!tick) begin
          presc <= presc + DIV_WIDTH'(1);
        end else begin
          presc <= '0;
          if (last_tick) begin
            tcnt   <= '0;
            exp_bt <= 1'b1;
            if (!last_bit) bidx <= bidx + 6'd1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
      end
      if (state == IDLE && bus.i_start) err <= 1'b0;
    end
  end

  assign bus.o_tick      = tick;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done_tick = (state == WRAP);
  assign bus.o_sync_err  = err;
endmodule

// File: tb/tb_diff_freq_tick_gen.sv
// tb/tb_diff_freq_tick_gen.sv - directed vector bench for diff_freq_tick_gen
module tb_diff_freq_tick_gen;
  localparam int DB = 4;
  localparam int TPB = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  diff_freq_tick_gen_if #(.DATA_BIT(DB), .DIV_WIDTH(DW)) bus ();

  diff_freq_tick_gen #(.DATA_BIT(DB), .TICK_PER_BIT(TPB), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DB-1:0] sel;
    logic [DW-1:0] hdiv;
    logic [DW-1:0] ldiv;
    int            len;
    logic [39:0]   tick_m;
    logic [39:0]   bt_m;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_inputs(input int v);
    bus.i_freq_sel = vecs[v].sel;
    bus.i_high_div = vecs[v].hdiv;
    bus.i_low_div  = vecs[v].ldiv;
  endtask

  task automatic start_frame(input int v);
    set_inputs(v);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  // Entered at cycle 1 of RUN; leaves one cycle after the WRAP cycle.
  task automatic run_frame(input int v, input int spur_c);
    for (int c = 1; c <= vecs[v].len + 1; c++) begin
      check($sformatf("v%0d c%0d tick", v, c), {31'd0, bus.o_tick}, {31'd0, vecs[v].tick_m[c-1]});
      check($sformatf("v%0d c%0d busy", v, c), {31'd0, bus.o_busy}, 32'd1);
      check($sformatf("v%0d c%0d done", v, c), {31'd0, bus.o_done_tick}, {31'd0, c == vecs[v].len + 1});
      check($sformatf("v%0d c%0d err", v, c), {31'd0, bus.o_sync_err}, {31'd0, spur_c != 0 && c > spur_c});
      bus.i_bit_tick = vecs[v].bt_m[c-1] | (c == spur_c);
      @(posedge clk); #1;
    end
    bus.i_bit_tick = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic err_exp);
    check({name, " busy"}, {31'd0, bus.o_busy}, 32'd0);
    check({name, " tick"}, {31'd0, bus.o_tick}, 32'd0);
    check({name, " done"}, {31'd0, bus.o_done_tick}, 32'd0);
    check({name, " err"}, {31'd0, bus.o_sync_err}, {31'd0, err_exp});
  endtask

  initial begin
    int tick_seen;
    int done_seen;

    // Masks: bit c-1 is RUN cycle c; bit len is the WRAP cycle.
    vecs[0] = '{4'b0000, 8'd0, 8'd2, 24, 40'h00_0092_4924, 40'h00_0104_1040};
    vecs[1] = '{4'b0101, 8'd0, 8'd3, 20, 40'h00_0008_8E23, 40'h00_0010_1404};
    vecs[2] = '{4'b1111, 8'd1, 8'd5, 16, 40'h00_0000_AAAA, 40'h00_0001_1110};
    vecs[3] = '{4'b1000, 8'd0, 8'd0,  8, 40'h00_0000_00FF, 40'h00_0000_0154};

    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_repeat = 1'b0;
    bus.i_freq_sel = '0; bus.i_high_div = '0; bus.i_low_div = '0; bus.i_bit_tick = 1'b0;
    #1;
    check_idle("reset", 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      start_frame(v);
      run_frame(v, 0);
      check_idle($sformatf("v%0d after", v), 1'b0);
    end

    // Repeat: frame 1 keeps the latched pattern, frame 2 picks up the new one.
    bus.i_repeat = 1'b1;
    start_frame(0);
    set_inputs(1);
    run_frame(0, 0);
    bus.i_repeat = 1'b0;
    run_frame(1, 0);
    check_idle("repeat after", 1'b0);

    // Stop on the 5th RUN clock.
    start_frame(0);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("stop c%0d tick", c), {31'd0, bus.o_tick}, {31'd0, vecs[0].tick_m[c-1]});
      if (c == 5) bus.i_stop = 1'b1;
      @(posedge clk); #1;
    end
    bus.i_stop = 1'b0;
    check_idle("stop next", 1'b0);
    tick_seen = 0; done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick_seen += int'(bus.o_tick);
      done_seen += int'(bus.o_done_tick);
      @(posedge clk); #1;
    end
    check("stop ticks after", tick_seen, 0);
    check("stop done after", done_seen, 0);

    // Stop coincident with the final tick: no WRAP.
    start_frame(3);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("fstop c%0d tick", c), {31'd0, bus.o_tick}, 32'd1);
      bus.i_bit_tick = vecs[3].bt_m[c-1];
      if (c == 8) bus.i_stop = 1'b1;
      @(posedge clk); #1;
    end
    bus.i_stop = 1'b0; bus.i_bit_tick = 1'b0;
    check_idle("fstop next", 1'b0);
    @(posedge clk); #1;
    check_idle("fstop next2", 1'b0);

    // Spurious bit tick on cycle 2: sticky until the next start.
    start_frame(0);
    run_frame(0, 2);
    check_idle("spur after", 1'b1);
    repeat (3) @(posedge clk); #1;
    check("spur held err", {31'd0, bus.o_sync_err}, 32'd1);
    start_frame(0);
    run_frame(0, 0);
    check_idle("spur cleared", 1'b0);

    // Asynchronous reset while a tick is being emitted.
    start_frame(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst pre tick", {31'd0, bus.o_tick}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("rst async", 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start_frame(0);
    run_frame(0, 0);
    check_idle("rst restart after", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
